// File: rtl/cic_building_blocks.sv
// Decimating CIC filter primitives (integrator, downsampler, comb) and a
// reference chain that wires N integrators, one decimator and N combs together.

module integrator #(
  parameter int DATA_WIDTH_INP = 18,
  parameter int DATA_WIDTH_OUT = 18
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic signed [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                             inp_samp_str,
  output logic signed [DATA_WIDTH_OUT-1:0] out_samp_data
);

  logic signed [DATA_WIDTH_INP-1:0] r_acc;

  // Modulo-2^W accumulation; CIC gain recovery in the combs relies on this wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (inp_samp_str) begin
      r_acc <= r_acc + inp_samp_data;
    end
  end

  // Hogenauer pruning: keep the MSBs, drop LSBs without rounding.
  assign out_samp_data = r_acc[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];

endmodule

module downsampler #(
  parameter int DATA_WIDTH_INP = 18,
  parameter int CIC_R          = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                      inp_samp_str,
  output logic [DATA_WIDTH_INP-1:0] out_samp_data,
  output logic                      out_samp_str
);

  localparam int                CNT_W    = (CIC_R > 1) ? $clog2(CIC_R) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CIC_R - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      out_samp_data <= '0;
      out_samp_str  <= 1'b0;
    end else if (inp_samp_str) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt         <= '0;
        out_samp_data <= inp_samp_data;
        out_samp_str  <= 1'b1;
      end else begin
        r_cnt         <= r_cnt + 1'b1;
        out_samp_str  <= 1'b0;
      end
    end else begin
      out_samp_str <= 1'b0;
    end
  end

endmodule

module comb #(
  parameter int SAMP_WIDTH = 18,
  parameter int CIC_M      = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         samp_inp_str,
  input  logic signed [SAMP_WIDTH-1:0] samp_inp_data,
  output logic                         samp_out_str,
  output logic signed [SAMP_WIDTH-1:0] samp_out_data
);

  logic signed [SAMP_WIDTH-1:0] r_delay [CIC_M];

  // Difference against the sample CIC_M strobes ago; the line only shifts on a strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_out_str  <= 1'b0;
      samp_out_data <= '0;
      for (int k = 0; k < CIC_M; k++) begin
        r_delay[k] <= '0;
      end
    end else begin
      samp_out_str <= samp_inp_str;
      if (samp_inp_str) begin
        samp_out_data <= samp_inp_data - r_delay[CIC_M-1];
        r_delay[0]    <= samp_inp_data;
        for (int k = 1; k < CIC_M; k++) begin
          r_delay[k] <= r_delay[k-1];
        end
      end
    end
  end

endmodule

module cic_building_blocks #(
  parameter int CIC_N      = 2,
  parameter int CIC_R      = 4,
  parameter int CIC_M      = 1,
  parameter int DATA_WIDTH = 18
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] i_samp_data,
  input  logic                         i_samp_str,
  output logic signed [DATA_WIDTH-1:0] o_samp_data,
  output logic                         o_samp_str
);

  logic signed [DATA_WIDTH-1:0] w_intData  [CIC_N+1];
  logic signed [DATA_WIDTH-1:0] w_combData [CIC_N+1];
  logic                         w_combStr  [CIC_N+1];
  logic        [DATA_WIDTH-1:0] w_dsData;
  logic                         w_dsStr;

  assign w_intData[0] = i_samp_data;

  // All integrators share the input strobe and each consumes the previous registered sum.
  for (genvar g = 0; g < CIC_N; g++) begin : g_int
    integrator #(
      .DATA_WIDTH_INP(DATA_WIDTH),
      .DATA_WIDTH_OUT(DATA_WIDTH)
    ) u_int (
      .clk          (clk),
      .reset_n      (reset_n),
      .inp_samp_data(w_intData[g]),
      .inp_samp_str (i_samp_str),
      .out_samp_data(w_intData[g+1])
    );
  end

  downsampler #(
    .DATA_WIDTH_INP(DATA_WIDTH),
    .CIC_R         (CIC_R)
  ) u_ds (
    .clk          (clk),
    .reset_n      (reset_n),
    .inp_samp_data(w_intData[CIC_N]),
    .inp_samp_str (i_samp_str),
    .out_samp_data(w_dsData),
    .out_samp_str (w_dsStr)
  );

  assign w_combData[0] = w_dsData;
  assign w_combStr[0]  = w_dsStr;

  for (genvar g = 0; g < CIC_N; g++) begin : g_comb
    comb #(
      .SAMP_WIDTH(DATA_WIDTH),
      .CIC_M     (CIC_M)
    ) u_comb (
      .clk          (clk),
      .reset_n      (reset_n),
      .samp_inp_str (w_combStr[g]),
      .samp_inp_data(w_combData[g]),
      .samp_out_str (w_combStr[g+1]),
      .samp_out_data(w_combData[g+1])
    );
  end

  assign o_samp_data = w_combData[CIC_N];
  assign o_samp_str  = w_combStr[CIC_N];

endmodule

// File: tb/tb_cic_building_blocks.sv
// Directed self-checking bench for the CIC primitives and the reference chain.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_cic_building_blocks;

  logic clk;
  logic reset_n;

  logic signed [7:0]  intDataA, intDataB, intOutA;
  logic signed [3:0]  intOutB;
  logic               intStrA, intStrB;
  logic        [7:0]  dsData, dsOut;
  logic               dsStr, dsOutStr;
  logic signed [7:0]  combIn, combOut;
  logic               combStr, combOutStr;
  logic signed [17:0] topIn, topOut;
  logic               topStr, topOutStr;

  int checks = 0;
  int errors = 0;

  cic_building_blocks #(.CIC_N(2), .CIC_R(4), .CIC_M(1), .DATA_WIDTH(18)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_samp_data(topIn), .i_samp_str(topStr),
    .o_samp_data(topOut), .o_samp_str(topOutStr)
  );

  integrator #(8, 8) u_intA (
    .clk(clk), .reset_n(reset_n),
    .inp_samp_data(intDataA), .inp_samp_str(intStrA), .out_samp_data(intOutA)
  );

  integrator #(8, 4) u_intB (
    .clk(clk), .reset_n(reset_n),
    .inp_samp_data(intDataB), .inp_samp_str(intStrB), .out_samp_data(intOutB)
  );

  downsampler #(.DATA_WIDTH_INP(8), .CIC_R(4)) u_ds (
    .clk(clk), .reset_n(reset_n),
    .inp_samp_data(dsData), .inp_samp_str(dsStr),
    .out_samp_data(dsOut), .out_samp_str(dsOutStr)
  );

  comb #(.SAMP_WIDTH(8), .CIC_M(2)) u_comb (
    .clk(clk), .reset_n(reset_n),
    .samp_inp_str(combStr), .samp_inp_data(combIn),
    .samp_out_str(combOutStr), .samp_out_data(combOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    intDataA = '0; intStrA = 1'b0; intDataB = '0; intStrB = 1'b0;
    dsData = '0; dsStr = 1'b0; combIn = '0; combStr = 1'b0;
    topIn = '0; topStr = 1'b0;
    #2;
    checks++; if (intOutA !== 8'sd0) begin errors++; $display("[TB] FAIL reset_intA got %0d expected 0", intOutA); end
    checks++; if (intOutB !== 4'sd0) begin errors++; $display("[TB] FAIL reset_intB got %0d expected 0", intOutB); end
    checks++; if (dsOut !== 8'd0 || dsOutStr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ds got data %0d str %b expected 0 0", dsOut, dsOutStr); end
    checks++; if (combOut !== 8'sd0 || combOutStr !== 1'b0) begin errors++; $display("[TB] FAIL reset_comb got data %0d str %b expected 0 0", combOut, combOutStr); end
    checks++; if (topOut !== 18'sd0 || topOutStr !== 1'b0) begin errors++; $display("[TB] FAIL reset_top got data %0d str %b expected 0 0", topOut, topOutStr); end
    #10;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_integrator_accumulate();
    for (int i = 1; i <= 4; i++) begin
      intStrA = 1'b1; intDataA = 8'sd5;
      tick();
      intStrA = 1'b0;
      checks++;
      if (intOutA !== 8'(5 * i)) begin errors++; $display("[TB] FAIL int_acc step %0d got %0d expected %0d", i, intOutA, 5 * i); end
    end
    intDataA = 8'sd99;
    tick();
    tick();
    checks++; if (intOutA !== 8'sd20) begin errors++; $display("[TB] FAIL int_hold got %0d expected 20", intOutA); end
  endtask

  task automatic test_integrator_wrap();
    intStrB = 1'b1; intDataB = 8'sd100;
    tick();
    checks++; if (intOutB !== 4'h6) begin errors++; $display("[TB] FAIL int_prune_first got %h expected 6", intOutB); end
    tick();
    intStrB = 1'b0;
    checks++; if (intOutB !== 4'hC) begin errors++; $display("[TB] FAIL int_wrap got %h expected c", intOutB); end
  endtask

  task automatic test_downsampler();
    int pulses;
    logic [7:0] expData;
    logic expStr;
    pulses = 0;
    for (int v = 1; v <= 8; v++) begin
      dsStr = 1'b1; dsData = 8'(v);
      tick();
      dsStr = 1'b0;
      expStr  = (v % 4 == 0);
      expData = (v < 4) ? 8'd0 : ((v < 8) ? 8'd4 : 8'd8);
      if (dsOutStr === 1'b1) pulses++;
      checks++;
      if (dsOutStr !== expStr || dsOut !== expData) begin
        errors++; $display("[TB] FAIL ds_strobe %0d got data %0d str %b expected %0d %b", v, dsOut, dsOutStr, expData, expStr);
      end
      tick();
      if (dsOutStr === 1'b1) pulses++;
      checks++;
      if (dsOutStr !== 1'b0 || dsOut !== expData) begin
        errors++; $display("[TB] FAIL ds_gap %0d got data %0d str %b expected %0d 0", v, dsOut, dsOutStr, expData);
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("[TB] FAIL ds_pulse_count got %0d expected 2", pulses); end
  endtask

  task automatic test_comb();
    logic signed [7:0] vin [4];
    logic signed [7:0] vexp [4];
    vin  = '{8'sd3, 8'sd7, 8'sd10, 8'sd20};
    vexp = '{8'sd3, 8'sd7, 8'sd7, 8'sd13};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (combOutStr !== 1'b0) begin errors++; $display("[TB] FAIL comb_str_idle %0d got %b expected 0", i, combOutStr); end
      combStr = 1'b1; combIn = vin[i];
      tick();
      combStr = 1'b0;
      checks++;
      if (combOutStr !== 1'b1 || combOut !== vexp[i]) begin
        errors++; $display("[TB] FAIL comb_out %0d got data %0d str %b expected %0d 1", i, combOut, combOutStr, vexp[i]);
      end
      combIn = 8'sd55;
      tick();
      checks++;
      if (combOutStr !== 1'b0 || combOut !== vexp[i]) begin
        errors++; $display("[TB] FAIL comb_hold %0d got data %0d str %b expected %0d 0", i, combOut, combOutStr, vexp[i]);
      end
    end
  endtask

  task automatic test_chain();
    logic signed [17:0] vexp [4];
    logic signed [17:0] last;
    int pulses;
    vexp = '{18'sd3, 18'sd15, 18'sd16, 18'sd16};
    pulses = 0;
    last = '0;
    topIn = 18'sd1;
    for (int c = 0; c < 44; c++) begin
      topStr = (c < 40);
      tick();
      if (topOutStr === 1'b1) begin
        if (pulses < 4) begin
          checks++;
          if (topOut !== vexp[pulses]) begin errors++; $display("[TB] FAIL chain_out %0d got %0d expected %0d", pulses, topOut, vexp[pulses]); end
        end
        last = topOut;
        pulses++;
      end
    end
    topStr = 1'b0;
    checks++; if (pulses != 10) begin errors++; $display("[TB] FAIL chain_pulse_count got %0d expected 10", pulses); end
    checks++; if (last !== 18'sd16) begin errors++; $display("[TB] FAIL chain_settled got %0d expected 16", last); end
  endtask

  task automatic test_reset_midstream();
    intStrA = 1'b1; intDataA = 8'sd1; dsStr = 1'b1; dsData = 8'd9;
    tick();
    intStrA = 1'b0; dsData = 8'd10;
    tick();
    dsStr = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (intOutA !== 8'sd0 || intOutB !== 4'sd0) begin errors++; $display("[TB] FAIL mid_reset_int got %0d %0d expected 0 0", intOutA, intOutB); end
    checks++; if (dsOut !== 8'd0 || dsOutStr !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ds got %0d %b expected 0 0", dsOut, dsOutStr); end
    checks++; if (combOut !== 8'sd0 || topOut !== 18'sd0) begin errors++; $display("[TB] FAIL mid_reset_comb_top got %0d %0d expected 0 0", combOut, topOut); end
    #2;
    reset_n = 1'b1;
    for (int v = 11; v <= 14; v++) begin
      dsStr = 1'b1; dsData = 8'(v);
      intStrA = (v == 11); intDataA = 8'sd7;
      tick();
      checks++;
      if (dsOutStr !== (v == 14) || dsOut !== ((v == 14) ? 8'd14 : 8'd0)) begin
        errors++; $display("[TB] FAIL post_reset_ds %0d got data %0d str %b expected %0d %b", v, dsOut, dsOutStr, (v == 14) ? 14 : 0, (v == 14));
      end
    end
    dsStr = 1'b0; intStrA = 1'b0;
    tick();
    checks++; if (intOutA !== 8'sd7) begin errors++; $display("[TB] FAIL post_reset_int got %0d expected 7", intOutA); end
    checks++; if (dsOutStr !== 1'b0 || dsOut !== 8'd14) begin errors++; $display("[TB] FAIL post_reset_ds_hold got %0d %b expected 14 0", dsOut, dsOutStr); end
  endtask

  initial begin
    test_reset();
    test_integrator_accumulate();
    test_integrator_wrap();
    test_downsampler();
    test_comb();
    test_chain();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_building_blocks.md
# cic_building_blocks

Library of the three primitives a decimating CIC filter is built from: `integrator`, `downsampler`, and `comb`. The filter top chains N integrators at the input rate, then one downsampler by R, then N combs at the output rate. Stage widths are set per instance by parameters, which lets the top prune LSBs Hogenauer-style. All arithmetic is two's complement and wraps modulo 2^width; CIC correctness depends on this wrap.

## Interface
Parameters:
- `integrator.DATA_WIDTH_INP` (positional 1st), default 18: accumulator width and input width.
- `integrator.DATA_WIDTH_OUT` (positional 2nd), default 18: output width, ≤ `DATA_WIDTH_INP`.
- `downsampler.DATA_WIDTH_INP`, default 18: data width, in and out.
- `downsampler.CIC_R`, default 10: decimation ratio, ≥1.
- `comb.SAMP_WIDTH`, default 18: data width, in and out.
- `comb.CIC_M`, default 1: differential delay in samples, ≥1.

Ports. All modules have `clk` (in, 1) and `reset_n` (in, 1). Reset is asynchronous and active-low; `clk` is the clock.
- integrator:
  - `inp_samp_data`: in, `DATA_WIDTH_INP`, signed.
  - `inp_samp_str`: in, 1, input valid.
  - `out_samp_data`: out, `DATA_WIDTH_OUT`, signed.
- downsampler:
  - `inp_samp_data`: in, `DATA_WIDTH_INP`.
  - `inp_samp_str`: in, 1.
  - `out_samp_data`: out, `DATA_WIDTH_INP`.
  - `out_samp_str`: out, 1, one-cycle pulse.
- comb:
  - `samp_inp_str`: in, 1.
  - `samp_inp_data`: in, `SAMP_WIDTH`, signed.
  - `samp_out_str`: out, 1.
  - `samp_out_data`: out, `SAMP_WIDTH`, signed.

## Operation
- integrator:
  - Register `acc` is `DATA_WIDTH_INP` bits wide.
  - On a clk edge with `inp_samp_str`=1: `acc <= acc + inp_samp_data`, with wraparound and no saturation. With the strobe low, `acc` holds.
  - `out_samp_data = acc[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT]`. This is a truncation that drops LSBs; there is no rounding.
- downsampler:
  - Counter `cnt` runs 0..CIC_R-1 and advances only on `inp_samp_str`.
  - On a strobe with `cnt`==CIC_R-1: `out_samp_data <= inp_samp_data`, `out_samp_str <= 1`, and `cnt <= 0`.
  - On any other strobe: `cnt <= cnt+1` and `out_samp_str <= 0`.
  - With no strobe: `out_samp_str <= 0`, and data and `cnt` hold.
  - The first output is on the CIC_R-th strobe after reset. CIC_R=1 passes every sample through.
- comb:
  - Delay line `d[0..CIC_M-1]`, `SAMP_WIDTH` bits each.
  - On `samp_inp_str`=1: `samp_out_data <= samp_inp_data - d[CIC_M-1]` (wraparound), then `d[0] <= samp_inp_data` and `d[k] <= d[k-1]`.
  - With the strobe low, data and delay line hold.
  - `samp_out_str <= samp_inp_str` every cycle.
- Intended chaining in the filter top:
  - Integrators share one strobe; each feeds on the previous stage's registered output, forming a pipeline.
  - Combs chain via `samp_out_str` to `samp_inp_str`.

## Timing
- Reset values: every register is cleared to 0 (`acc`, `cnt`, delay lines, all data outputs, all strobes). Asserting reset mid-operation clears state immediately, independent of clk.
- integrator latency: 1 cycle from strobe to updated output.
- downsampler: `out_samp_str` is asserted for exactly one cycle, the cycle after the CIC_R-th strobe, with the data valid in that same cycle. Data holds until the next decimated sample.
- comb: `samp_out_str` and data are valid 1 cycle after `samp_inp_str`. Back-to-back strobes on consecutive cycles are supported by all three blocks at full throughput.
- No backpressure; strobes are single-cycle qualifiers.

## Test plan
- Integrator accumulate: DW_IN=DW_OUT=8; drive 5 on 4 consecutive strobes → `out_samp_data` reads 5, 10, 15, 20, one cycle after each strobe; then strobe low → output holds at 20.
- Integrator wrap and prune: DW_IN=8, DW_OUT=4; apply strobes with input 100, then 100 → acc = 200 wraps to -56 (0xC8), so `out_samp_data` = 0xC = -4.
- Downsampler: CIC_R=4; strobe inputs 1..8 with gaps between strobes → exactly two 1-cycle pulses, with data 4 and 8; `cnt` ignores cycles without a strobe.
- Comb: CIC_M=2; inputs 3, 7, 10, 20 → outputs 3, 7, 7, 13; `samp_out_str` is delayed one cycle from the input strobe.
- Reset mid-stream: assert `reset_n`=0 asynchronously between clock edges during activity → all outputs read 0 immediately. After release, the downsampler's first pulse comes on the CIC_R-th new strobe.
- Chain check: 2 integrators, a downsampler with R=4, and 2 combs with M=1, full widths; constant input 1 → settled output = (R·M)^N = 16.
